// File: rtl/fifo_rd_drain.sv
// Read-side drain for the async FIFO: pops on !r_empty, stages returned data in a 2-entry
// buffer, and presents it as a valid/ready stream. Optional stats under FIFO_RD_DRAIN_STATS_EN.
module fifo_rd_drain #(
    parameter int unsigned bus_width   = 8,
    parameter int unsigned STAGE_DEPTH = 2
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic                 flush,
    input  logic                 r_empty,
    input  logic [bus_width-1:0] r_data,
    output logic                 r_en,
    output logic                 m_valid,
    output logic [bus_width-1:0] m_data,
    input  logic                 m_ready,
    output logic [1:0]           occupancy
`ifdef FIFO_RD_DRAIN_STATS_EN
    ,
    output logic [15:0]          beat_cnt,
    output logic [0:0]           stall_seen
`endif
);

    logic [bus_width-1:0] stage_q [STAGE_DEPTH];
    logic [1:0]           occ_q, occ_d;
    logic                 infl_q;
    logic                 wr_ptr_q, rd_ptr_q;
    logic                 pop, cap;
    logic [2:0]           level;

    always_comb begin
        pop   = m_valid && m_ready;
        cap   = infl_q && !flush;
        // Slots committed after this edge: staged + arriving - leaving.
        level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
        r_en  = r_rst && !r_empty && !flush && (level < 3'd2);
        occ_d = flush ? 2'd0 : (occ_q + {1'b0, cap} - {1'b0, pop});
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            for (int i = 0; i < STAGE_DEPTH; i++) stage_q[i] <= '0;
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            infl_q <= r_en;
            occ_q  <= occ_d;
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (cap) begin
                    stage_q[wr_ptr_q] <= r_data;
                    wr_ptr_q          <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = stage_q[rd_ptr_q];
    assign occupancy = occ_q;

`ifdef FIFO_RD_DRAIN_STATS_EN
    logic [15:0] beat_cnt_q;
    logic        stall_q;

    // Counts every accepted beat; flush does not reset statistics.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            beat_cnt_q <= 16'd0;
            stall_q    <= 1'b0;
        end else begin
            if (pop) beat_cnt_q <= beat_cnt_q + 16'd1;
            if (m_valid && !m_ready) stall_q <= 1'b1;
        end
    end

    assign beat_cnt   = beat_cnt_q;
    assign stall_seen = stall_q;
`endif

    occ_bound: assert property (@(posedge r_clk) disable iff (!r_rst) occ_q <= 2'd2);

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a behavioural one-cycle-latency FIFO on the read side.
module tb_fifo_rd_drain;

    logic       r_clk;
    logic       r_rst;
    logic       flush;
    logic       r_empty;
    logic [7:0] r_data;
    logic       r_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [1:0] occupancy;
`ifdef FIFO_RD_DRAIN_STATS_EN
    logic [15:0] beat_cnt;
    logic [0:0]  stall_seen;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] fifo_mem [64];
    int         fifo_wr = 0;
    int         fifo_rd = 0;

    fifo_rd_drain #(
        .bus_width  (8),
        .STAGE_DEPTH(2)
    ) dut (
        .r_clk     (r_clk),
        .r_rst     (r_rst),
        .flush     (flush),
        .r_empty   (r_empty),
        .r_data    (r_data),
        .r_en      (r_en),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .occupancy (occupancy)
`ifdef FIFO_RD_DRAIN_STATS_EN
        ,
        .beat_cnt  (beat_cnt),
        .stall_seen(stall_seen)
`endif
    );

    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    // FIFO model: data appears on r_data the cycle after an accepted r_en.
    assign r_empty = (fifo_wr == fifo_rd);
    initial r_data = 8'h00;
    always @(posedge r_clk) begin
        if (r_en) begin
            r_data  <= fifo_mem[fifo_rd[5:0]];
            fifo_rd <= fifo_rd + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        fifo_mem[fifo_wr[5:0]] = d;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge r_clk);
    endtask

    initial begin
        r_rst   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);

        // 1: reset holds everything at zero even though the FIFO is non-empty
        step(); #1;
        chk("rst_r_en", 16'(r_en), 16'd0);
        chk("rst_m_valid", 16'(m_valid), 16'd0);
        chk("rst_m_data", 16'(m_data), 16'h00);
        chk("rst_occ", 16'(occupancy), 16'd0);
        step(); #1;
        chk("rst_r_en_2", 16'(r_en), 16'd0);
`ifdef FIFO_RD_DRAIN_STATS_EN
        chk("rst_beat_cnt", beat_cnt, 16'd0);
        chk("rst_stall", 16'(stall_seen), 16'd0);
`endif

        // 2: streaming 0x11,0x22,0x33 with m_ready=1
        step(); r_rst = 1'b1; m_ready = 1'b1; #1;
        chk("s_c0_r_en", 16'(r_en), 16'd1);
        step(); #1;
        chk("s_c1_r_en", 16'(r_en), 16'd1);
        chk("s_c1_valid", 16'(m_valid), 16'd0);
        step(); #1;
        chk("s_c2_r_en", 16'(r_en), 16'd1);
        chk("s_c2_valid", 16'(m_valid), 16'd1);
        chk("s_c2_data", 16'(m_data), 16'h11);
        step(); #1;
        chk("s_c3_r_en", 16'(r_en), 16'd0);
        chk("s_c3_data", 16'(m_data), 16'h22);
        step(); #1;
        chk("s_c4_valid", 16'(m_valid), 16'd1);
        chk("s_c4_data", 16'(m_data), 16'h33);
        step(); #1;
        chk("s_c5_valid", 16'(m_valid), 16'd0);
        chk("s_c5_occ", 16'(occupancy), 16'd0);
`ifdef FIFO_RD_DRAIN_STATS_EN
        chk("s_stall", 16'(stall_seen), 16'd0);
`endif

        // 3: backpressure with 5 entries
        step(); m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'(8'h40 + i));
        #1;
        chk("bp_d0_r_en", 16'(r_en), 16'd1);
        step(); #1;
        chk("bp_d1_r_en", 16'(r_en), 16'd1);
        step(); #1;
        chk("bp_d2_r_en", 16'(r_en), 16'd0);
        step(); #1;
        chk("bp_d3_r_en", 16'(r_en), 16'd0);
        chk("bp_d3_occ", 16'(occupancy), 16'd2);
        chk("bp_d3_data", 16'(m_data), 16'h41);
        step(); #1;
        chk("bp_d4_r_en", 16'(r_en), 16'd0);
        chk("bp_d4_occ", 16'(occupancy), 16'd2);
`ifdef FIFO_RD_DRAIN_STATS_EN
        chk("bp_stall", 16'(stall_seen), 16'd1);
`endif
        step(); m_ready = 1'b1; #1;
        chk("bp_d5_r_en", 16'(r_en), 16'd1);
        chk("bp_d5_data", 16'(m_data), 16'h41);
        step(); #1;
        chk("bp_d6_data", 16'(m_data), 16'h42);
        chk("bp_d6_r_en", 16'(r_en), 16'd1);
        step(); #1;
        chk("bp_d7_data", 16'(m_data), 16'h43);
        step(); #1;
        chk("bp_d8_data", 16'(m_data), 16'h44);
        chk("bp_d8_r_en", 16'(r_en), 16'd0);
        step(); #1;
        chk("bp_d9_data", 16'(m_data), 16'h45);
        chk("bp_d9_valid", 16'(m_valid), 16'd1);
        step(); #1;
        chk("bp_d10_valid", 16'(m_valid), 16'd0);

        // 4: flush with one staged entry and one read in flight
        step(); m_ready = 1'b0;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        step(); #1;
        step(); flush = 1'b1; #1;
        chk("fl_e2_occ", 16'(occupancy), 16'd1);
        chk("fl_e2_r_en", 16'(r_en), 16'd0);
        step(); flush = 1'b0; #1;
        chk("fl_e3_valid", 16'(m_valid), 16'd0);
        chk("fl_e3_occ", 16'(occupancy), 16'd0);
        chk("fl_e3_r_en", 16'(r_en), 16'd1);
`ifdef FIFO_RD_DRAIN_STATS_EN
        chk("fl_beat_cnt", beat_cnt, 16'd8);
        chk("fl_stall", 16'(stall_seen), 16'd1);
`endif
        step(); #1;
        chk("fl_e4_valid", 16'(m_valid), 16'd0);
        step(); m_ready = 1'b1; #1;
        chk("fl_e5_valid", 16'(m_valid), 16'd1);
        chk("fl_e5_data", 16'(m_data), 16'h53);
        step(); #1;
        chk("fl_e6_valid", 16'(m_valid), 16'd0);

        // 5: single entry 0xA5 held until accepted
        m_ready = 1'b0;
        #1;
        chk("one_idle_r_en", 16'(r_en), 16'd0);
        step(); push(8'hA5); #1;
        chk("one_f0_r_en", 16'(r_en), 16'd1);
        step(); #1;
        chk("one_f1_r_en", 16'(r_en), 16'd0);
        step(); #1;
        chk("one_f2_valid", 16'(m_valid), 16'd1);
        chk("one_f2_data", 16'(m_data), 16'hA5);
        step(); #1;
        chk("one_f3_data", 16'(m_data), 16'hA5);
        chk("one_f3_r_en", 16'(r_en), 16'd0);
        step(); m_ready = 1'b1; #1;
        chk("one_f4_valid", 16'(m_valid), 16'd1);
        step(); #1;
        chk("one_f5_valid", 16'(m_valid), 16'd0);
        chk("one_f5_r_en", 16'(r_en), 16'd0);

`ifdef FIFO_RD_DRAIN_STATS_EN
        // 6: 10 beats so far; 65527 more wraps the counter to 0x0001
        chk("st_beat_10", beat_cnt, 16'd10);
        begin
            int pushed;
            int k;
            pushed = 0;
            while (pushed < 65527) begin
                step();
                while ((fifo_wr - fifo_rd) < 16 && pushed < 65527) begin
                    push(8'(pushed));
                    pushed++;
                end
            end
            k = 0;
            step();
            while (k < 200 && !(r_empty && !m_valid)) begin
                step();
                k++;
            end
            #1;
            chk("st_drain_done", 16'(k < 200), 16'd1);
        end
        chk("st_beat_wrap", beat_cnt, 16'h0001);
        chk("st_stall_held", 16'(stall_seen), 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
